// File: rtl/wiphy_pkg.sv
// Shared definitions for the wireless PHY transmit/receive chain.
//   sample_t    : complex baseband sample {q, i}, each Q1.15
//   tx_state_t  : transmit framer states
//   sts_sample  : 802.11a short-training-sequence lookup (16 samples, Q1.15),
//                 also intended for the synchronization reference correlators
package wiphy_pkg;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] i;
  } sample_t;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    PAYLOAD,
    TAIL
  } tx_state_t;

  localparam int unsigned STS_LEN = 16;

  // One period of the 802.11a short training symbol, scaled to Q1.15.
  function automatic sample_t sts_sample(input logic [3:0] idx);
    sample_t s;
    case (idx)
      4'd0:    s = '{q: 16'h05E3, i: 16'h05E3};
      4'd1:    s = '{q: 16'h0042, i: 16'hEF1B};
      4'd2:    s = '{q: 16'hF5E3, i: 16'hFE56};
      4'd3:    s = '{q: 16'hFE56, i: 16'h124E};
      4'd4:    s = '{q: 16'h0000, i: 16'h0BC7};
      4'd5:    s = '{q: 16'hFE56, i: 16'h124E};
      4'd6:    s = '{q: 16'hF5E3, i: 16'hFE56};
      4'd7:    s = '{q: 16'h0042, i: 16'hEF1B};
      4'd8:    s = '{q: 16'h05E3, i: 16'h05E3};
      4'd9:    s = '{q: 16'hEF1B, i: 16'h0042};
      4'd10:   s = '{q: 16'hFE56, i: 16'hF5E3};
      4'd11:   s = '{q: 16'h124E, i: 16'hFE56};
      4'd12:   s = '{q: 16'h0BC7, i: 16'h0000};
      4'd13:   s = '{q: 16'h124E, i: 16'hFE56};
      4'd14:   s = '{q: 16'hFE56, i: 16'hF5E3};
      default: s = '{q: 16'hEF1B, i: 16'h0042};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tx_framer_preamble_rom.sv
// Combinational short-training-sequence ROM.
//   addr : sample index within the preamble symbol
//   data : {q, i} sample, Q1.15
module preamble_rom
  import wiphy_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [31:0]       data
);

  logic [3:0] addr4;

  always_comb begin
    addr4 = 4'(addr);
    data  = sts_sample(addr4);
  end

endmodule

// File: rtl/tx_framer.sv
// Transmit burst framer: preamble + payload + zero tail, paced by the DAC.
//   clk, aresetn          : sample clock, async active-low reset
//   enable                : allows a new burst to start (checked in IDLE only)
//   s_valid/s_ready/s_data/s_last : payload stream, {q, i} Q1.15
//   dac_valid             : DAC consumed dac_data this cycle
//   dac_data              : registered sample to the DAC
//   busy                  : burst in progress
//   underrun              : one-cycle pulse per starved payload strobe
//   done                  : one-cycle pulse when the burst ends
module tx_framer
  import wiphy_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN  = 16,
  parameter int unsigned PREAMBLE_REPS = 10,
  parameter int unsigned TAIL_LEN      = 8
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        enable,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  input  logic        dac_valid,
  output logic [31:0] dac_data,
  output logic        busy,
  output logic        underrun,
  output logic        done
);

  localparam int unsigned IDX_W = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(PREAMBLE_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [7:0]       REP_LAST  = 8'(PREAMBLE_REPS - 1);
  localparam logic [7:0]       TAIL_LAST = 8'(TAIL_LEN - 1);

  tx_state_t        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       rep_q, rep_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [31:0]      data_d;
  logic             underrun_d;
  logic             done_d;
  logic [31:0]      sts_word;

  preamble_rom #(
    .ADDR_W(IDX_W)
  ) u_rom (
    .addr(idx_q),
    .data(sts_word)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rep_d      = rep_q;
    cnt_d      = cnt_q;
    data_d     = dac_data;
    underrun_d = 1'b0;
    done_d     = 1'b0;
    s_ready    = 1'b0;

    case (state_q)
      IDLE: begin
        if (dac_valid) data_d = '0;
        // The first payload word is only peeked here; it is consumed in PAYLOAD.
        if (enable && s_valid) begin
          state_d = PREAMBLE;
          idx_d   = '0;
          rep_d   = '0;
        end
      end

      PREAMBLE: begin
        if (dac_valid) begin
          data_d = sts_word;
          idx_d  = idx_q + IDX_ONE;
          if (idx_q == IDX_LAST) begin
            rep_d = rep_q + 8'd1;
            if (rep_q == REP_LAST) state_d = PAYLOAD;
          end
        end
      end

      PAYLOAD: begin
        s_ready = dac_valid;
        if (dac_valid) begin
          if (s_valid) begin
            data_d = s_data;
            if (s_last) begin
              state_d = TAIL;
              cnt_d   = '0;
            end
          end else begin
            data_d     = '0;
            underrun_d = 1'b1;
          end
        end
      end

      TAIL: begin
        if (dac_valid) begin
          data_d = '0;
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == TAIL_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      rep_q    <= '0;
      cnt_q    <= '0;
      dac_data <= '0;
      underrun <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rep_q    <= rep_d;
      cnt_q    <= cnt_d;
      dac_data <= data_d;
      underrun <= underrun_d;
      done     <= done_d;
    end
  end

  always_comb busy = (state_q != IDLE);

endmodule
